// File: rtl/fwd_hazard_unit_pkg.sv
// Shared pipeline-tracking types: forwarding select encodings, the slot tuple
// and its bubble value. The execute stage imports the same encodings.
package fwd_hazard_unit_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        NO_FWD  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             mem_read;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '{valid: 1'b0, rd: '0, reg_write: 1'b0, mem_read: 1'b0};

    // x0 is hardwired, so a slot targeting it never counts as a producer.
    function automatic logic slot_writes(input slot_t s, input logic [REG_W-1:0] r);
        return s.valid && s.reg_write && (s.rd == r) && (r != '0);
    endfunction

    // The EX slot is younger than MEM, so it is tested first.
    function automatic fwd_sel_e fwd_select(input slot_t ex, input slot_t mem,
                                            input logic used, input logic [REG_W-1:0] r);
        if (!used)
            return NO_FWD;
        if (slot_writes(ex, r))
            return FWD_MEM;
        if (slot_writes(mem, r))
            return FWD_WB;
        return NO_FWD;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_hazard_slot.sv
// One pipeline shadow slot: clears on reset, loads on advance, otherwise holds.
module hazard_slot
    import fwd_hazard_unit_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_load,
    input  slot_t i_d,
    output slot_t o_q
);

    slot_t r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q <= SLOT_BUBBLE;
        else if (i_load)
            r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Tracks EX/MEM/WB destination state, registers forwarding selects for the
// instruction entering EXEC, and detects load-use hazards at decode.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ID_valid,
    input  logic [REG_W-1:0] ID_rs1,
    input  logic [REG_W-1:0] ID_rs2,
    input  logic             ID_rs1Used,
    input  logic             ID_rs2Used,
    input  logic [REG_W-1:0] ID_rd,
    input  logic             ID_regWrite,
    input  logic             ID_memRead,
    input  logic             flush,
    input  logic             memStall,
    output logic             stall,
    output logic [1:0]       EX_fwdRs1,
    output logic [1:0]       EX_fwdRs2,
    output logic             EX_valid,
    output logic [CNT_W-1:0] loadUseCount
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // w_slot[0] is the value entering EX; w_slot[1..3] are EX, MEM, WB.
    slot_t w_slot [0:3];
    slot_t w_ex;
    slot_t w_mem;
    slot_t w_wb;

    logic       w_advance;
    logic       w_hazard;
    logic       w_insert;
    fwd_sel_e   w_fwd_rs1;
    fwd_sel_e   w_fwd_rs2;

    logic [1:0]       r_fwd_rs1;
    logic [1:0]       r_fwd_rs2;
    logic [CNT_W-1:0] r_cnt;

    assign w_ex  = w_slot[1];
    assign w_mem = w_slot[2];
    assign w_wb  = w_slot[3];

    assign w_advance = !memStall;

    assign w_hazard = w_ex.valid && w_ex.mem_read && ID_valid &&
                      ((ID_rs1Used && slot_writes(w_ex, ID_rs1)) ||
                       (ID_rs2Used && slot_writes(w_ex, ID_rs2)));

    assign stall    = w_hazard && !flush && !memStall;
    assign w_insert = ID_valid && !flush && !stall;

    always_comb begin
        w_slot[0] = SLOT_BUBBLE;
        if (w_insert) begin
            w_slot[0].valid     = 1'b1;
            w_slot[0].rd        = ID_rd;
            w_slot[0].reg_write = ID_regWrite;
            w_slot[0].mem_read  = ID_memRead;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_slot
            hazard_slot u_slot (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_load (w_advance),
                .i_d    (w_slot[gi]),
                .o_q    (w_slot[gi+1])
            );
        end
    endgenerate

    assign w_fwd_rs1 = fwd_select(w_ex, w_mem, ID_rs1Used, ID_rs1);
    assign w_fwd_rs2 = fwd_select(w_ex, w_mem, ID_rs2Used, ID_rs2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_rs1 <= NO_FWD;
            r_fwd_rs2 <= NO_FWD;
        end else if (w_advance) begin
            r_fwd_rs1 <= w_insert ? w_fwd_rs1 : NO_FWD;
            r_fwd_rs2 <= w_insert ? w_fwd_rs2 : NO_FWD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (stall && (r_cnt != '1))
            r_cnt <= r_cnt + CNT_ONE;
    end

    // WB is kept purely as a shadow of retiring state; this pins its behaviour.
    a_wb_follows_mem: assert property (@(posedge clk) disable iff (!rst_n)
        !memStall |=> (w_wb == $past(w_mem)));

    assign EX_fwdRs1    = r_fwd_rs1;
    assign EX_fwdRs2    = r_fwd_rs2;
    assign EX_valid     = w_ex.valid;
    assign loadUseCount = r_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: an in-flight instruction model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_fwd_hazard_unit;

    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ID_valid = 1'b0;
    logic [4:0]       ID_rs1 = '0;
    logic [4:0]       ID_rs2 = '0;
    logic             ID_rs1Used = 1'b0;
    logic             ID_rs2Used = 1'b0;
    logic [4:0]       ID_rd = '0;
    logic             ID_regWrite = 1'b0;
    logic             ID_memRead = 1'b0;
    logic             flush = 1'b0;
    logic             memStall = 1'b0;
    logic             stall;
    logic [1:0]       EX_fwdRs1;
    logic [1:0]       EX_fwdRs2;
    logic             EX_valid;
    logic [CNT_W-1:0] loadUseCount;

    int n_cmp  = 0;
    int n_fail = 0;

    fwd_hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ID_valid     (ID_valid),
        .ID_rs1       (ID_rs1),
        .ID_rs2       (ID_rs2),
        .ID_rs1Used   (ID_rs1Used),
        .ID_rs2Used   (ID_rs2Used),
        .ID_rd        (ID_rd),
        .ID_regWrite  (ID_regWrite),
        .ID_memRead   (ID_memRead),
        .flush        (flush),
        .memStall     (memStall),
        .stall        (stall),
        .EX_fwdRs1    (EX_fwdRs1),
        .EX_fwdRs2    (EX_fwdRs2),
        .EX_valid     (EX_valid),
        .loadUseCount (loadUseCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: in-flight instructions by stage (0=EX, 1=MEM, 2=WB).
    logic             m_v  [3];
    logic [4:0]       m_rd [3];
    logic             m_we [3];
    logic             m_ld [3];
    logic [1:0]       m_f1;
    logic [1:0]       m_f2;
    logic [CNT_W-1:0] m_cnt;
    logic             e_stall;

    function automatic logic m_writes(input int s, input logic [4:0] r);
        return m_v[s] && m_we[s] && (m_rd[s] == r) && (r != 5'd0);
    endfunction

    function automatic logic [1:0] m_pick(input logic used, input logic [4:0] r);
        if (!used) return 2'b00;
        for (int s = 0; s < 2; s++)
            if (m_writes(s, r)) return (s == 0) ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    always_comb begin
        e_stall = ID_valid && m_v[0] && m_ld[0] && !flush && !memStall &&
                  ((ID_rs1Used && m_writes(0, ID_rs1)) || (ID_rs2Used && m_writes(0, ID_rs2)));
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 3; s++) begin
                m_v[s] <= 1'b0; m_rd[s] <= '0; m_we[s] <= 1'b0; m_ld[s] <= 1'b0;
            end
            m_f1  <= 2'b00;
            m_f2  <= 2'b00;
            m_cnt <= '0;
        end else if (!memStall) begin
            for (int s = 1; s < 3; s++) begin
                m_v[s] <= m_v[s-1]; m_rd[s] <= m_rd[s-1];
                m_we[s] <= m_we[s-1]; m_ld[s] <= m_ld[s-1];
            end
            if (ID_valid && !flush && !e_stall) begin
                m_v[0] <= 1'b1; m_rd[0] <= ID_rd; m_we[0] <= ID_regWrite; m_ld[0] <= ID_memRead;
                m_f1 <= m_pick(ID_rs1Used, ID_rs1);
                m_f2 <= m_pick(ID_rs2Used, ID_rs2);
            end else begin
                m_v[0] <= 1'b0; m_rd[0] <= '0; m_we[0] <= 1'b0; m_ld[0] <= 1'b0;
                m_f1 <= 2'b00;
                m_f2 <= 2'b00;
            end
            if (e_stall && (int'(m_cnt) < (2 ** CNT_W) - 1))
                m_cnt <= m_cnt + 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_stall", int'(stall), int'(e_stall));
            chk("cyc_ex_valid", int'(EX_valid), int'(m_v[0]));
            chk("cyc_fwd_rs1", int'(EX_fwdRs1), int'(m_f1));
            chk("cyc_fwd_rs2", int'(EX_fwdRs2), int'(m_f2));
            chk("cyc_count", int'(loadUseCount), int'(m_cnt));
        end
    end

    // Drive one decode-slot cycle; st reports the combinational stall seen before the edge.
    task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic we, input logic ld, input logic fl, input logic ms,
                        output logic st);
        ID_valid = v; ID_rs1 = rs1; ID_rs2 = rs2; ID_rs1Used = u1; ID_rs2Used = u2;
        ID_rd = rd; ID_regWrite = we; ID_memRead = ld; flush = fl; memStall = ms;
        #1;
        st = stall;
        @(posedge clk);
        #1;
        $display("step v=%0d rs1=%0d rs2=%0d rd=%0d we=%0d ld=%0d fl=%0d ms=%0d -> stall=%0d exv=%0d f1=%0d f2=%0d cnt=%0d",
                 v, rs1, rs2, rd, we, ld, fl, ms, st, EX_valid, EX_fwdRs1, EX_fwdRs2, loadUseCount);
    endtask

    task automatic nop(output logic st);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, st);
    endtask

    initial begin
        logic st;
        #3;
        chk("rst_stall", int'(stall), 0);
        chk("rst_ex_valid", int'(EX_valid), 0);
        chk("rst_fwd_rs1", int'(EX_fwdRs1), 0);
        chk("rst_fwd_rs2", int'(EX_fwdRs2), 0);
        chk("rst_count", int'(loadUseCount), 0);
        @(posedge clk); #1; rst_n = 1'b1;
        nop(st);

        // add x5,x1,x2 ; sub x6,x5,x1
        step(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, 0, st);
        step(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 0, 0, st);
        chk("b2b_stall", int'(st), 0);
        chk("b2b_fwd_rs1", int'(EX_fwdRs1), 1);
        chk("b2b_fwd_rs2", int'(EX_fwdRs2), 0);
        chk("b2b_ex_valid", int'(EX_valid), 1);

        // add x5 ; addi x9,x1 ; or x7,x1,x5
        step(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, 0, st);
        step(1, 5'd1, 5'd0, 1, 0, 5'd9, 1, 0, 0, 0, st);
        step(1, 5'd1, 5'd5, 1, 1, 5'd7, 1, 0, 0, 0, st);
        chk("dist2_fwd_rs1", int'(EX_fwdRs1), 0);
        chk("dist2_fwd_rs2", int'(EX_fwdRs2), 2);

        // add x5 ; addi x5,x5 ; xor x8,x5,x5
        step(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, 0, st);
        step(1, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0, st);
        chk("addi_fwd_rs1", int'(EX_fwdRs1), 1);
        step(1, 5'd5, 5'd5, 1, 1, 5'd8, 1, 0, 0, 0, st);
        chk("dbl_fwd_rs1", int'(EX_fwdRs1), 1);
        chk("dbl_fwd_rs2", int'(EX_fwdRs2), 1);

        // lw x3 ; add x4,x3,x3 (held through the stall)
        step(1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 1, 0, 0, st);
        chk("lu_count_before", int'(loadUseCount), 0);
        step(1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0, 0, 0, st);
        chk("lu_stall", int'(st), 1);
        chk("lu_bubble", int'(EX_valid), 0);
        chk("lu_count_after", int'(loadUseCount), 1);
        step(1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0, 0, 0, st);
        chk("lu_release_stall", int'(st), 0);
        chk("lu_ex_valid", int'(EX_valid), 1);
        chk("lu_fwd_rs1", int'(EX_fwdRs1), 2);
        chk("lu_fwd_rs2", int'(EX_fwdRs2), 2);

        // lw x3 ; add x4,x3 with coincident flush
        step(1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 1, 0, 0, st);
        step(1, 5'd3, 5'd2, 1, 1, 5'd4, 1, 0, 1, 0, st);
        chk("flush_stall", int'(st), 0);
        chk("flush_bubble", int'(EX_valid), 0);
        chk("flush_count", int'(loadUseCount), 1);
        nop(st);

        // lw x0 ; add x4,x0,x0
        step(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1, 0, 0, st);
        step(1, 5'd0, 5'd0, 1, 1, 5'd4, 1, 0, 0, 0, st);
        chk("x0_stall", int'(st), 0);
        chk("x0_fwd_rs1", int'(EX_fwdRs1), 0);
        chk("x0_fwd_rs2", int'(EX_fwdRs2), 0);
        chk("x0_ex_valid", int'(EX_valid), 1);

        // memStall for 3 cycles with FWD_MEM held, decode holding a flush+load-use candidate
        step(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 1, 0, 0, st);
        step(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 0, 0, st);
        chk("ms_pre_stall", int'(st), 1);
        step(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 0, 0, st);
        chk("ms_pre_fwd_rs1", int'(EX_fwdRs1), 2);
        step(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, 0, st);
        step(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 0, 0, st);
        for (int i = 0; i < 3; i++) begin
            step(1, 5'd6, 5'd0, 1, 0, 5'd7, 1, 0, 1, 1, st);
            chk("ms_stall", int'(st), 0);
            chk("ms_fwd_rs1", int'(EX_fwdRs1), 1);
            chk("ms_ex_valid", int'(EX_valid), 1);
        end
        step(1, 5'd6, 5'd0, 1, 0, 5'd7, 1, 0, 0, 0, st);
        chk("ms_release_fwd_rs1", int'(EX_fwdRs1), 1);
        chk("ms_release_ex_valid", int'(EX_valid), 1);

        // Async reset in the middle of a memStall hold
        step(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, 0, st);
        step(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 0, 0, st);
        step(1, 5'd5, 5'd5, 1, 1, 5'd7, 1, 0, 0, 1, st);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_stall", int'(stall), 0);
        chk("arst_ex_valid", int'(EX_valid), 0);
        chk("arst_fwd_rs1", int'(EX_fwdRs1), 0);
        chk("arst_fwd_rs2", int'(EX_fwdRs2), 0);
        chk("arst_count", int'(loadUseCount), 0);
        @(posedge clk); #1;
        memStall = 1'b0;
        rst_n = 1'b1;
        nop(st);

        // Counter saturation: nine load-use stalls on a 3-bit counter
        for (int i = 0; i < 9; i++) begin
            step(1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 1, 0, 0, st);
            step(1, 5'd3, 5'd0, 1, 0, 5'd4, 1, 0, 0, 0, st);
            step(1, 5'd3, 5'd0, 1, 0, 5'd4, 1, 0, 0, 0, st);
        end
        chk("sat_count", int'(loadUseCount), 7);
        nop(st);
        nop(st);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
